i2c_target_wb: RTL
==================

I2C_TARGET_WB -- requirements
Module: i2c_target_wb

Interface
REQ-001 The block SHALL have parameter I2C_ADDR, default 7'h42, the 7-bit target address it answers to.
REQ-002 The block SHALL have a single clock and a synchronous, active-high reset, with ports as listed below.
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- wb_adr_i  input  32  Wishbone address; bits [6:2] are decoded.
- wb_dat_i  input  32  Wishbone write data; bits [7:0] are used.
- wb_dat_o  output  32  Wishbone read data.
- wb_stb_i  input  1  Wishbone strobe.
- wb_cyc_i  input  1  Wishbone cycle.
- wb_we_i  input  1  Wishbone write enable.
- wb_sel_i  input  4  Wishbone byte select; the block honours only bit 0.
- wb_ack_o  output  1  Wishbone acknowledge.
- i2c_scl  input  1  I2C clock from the bus; the block never stretches it.
- i2c_sda  inout  1  I2C data, open-drain: driven 0 or high-Z, never driven 1.
- intr  output  1  sticky interrupt, active-high.

Function
REQ-003 The block SHALL pass i2c_scl and i2c_sda each through a 2-flop synchronizer and detect edges on the synchronized signals.
REQ-004 The block SHALL detect START when SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-005 START and STOP SHALL override every state, at any point in a transfer.
REQ-006 The block SHALL sample SDA on SCL rising edges, MSB first.
REQ-007 The block SHALL change its SDA output enable only on SCL falling edges.
REQ-008 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA and RACK.
REQ-009 START SHALL move the FSM to ADDR with the bit counter at 0, from any state; a repeated START SHALL retain the pointer.
REQ-010 ADDR state, 8th bit:
- Address match: the FSM enters ADDR_ACK and drives SDA low for one SCL period.
- Mismatch: the FSM returns to IDLE, does not drive SDA, and ignores the bus until the next START.
REQ-011 After ADDR_ACK, the FSM goes to PTR if R/W=0, or to RDATA if R/W=1.
REQ-012 PTR: the received byte[3:0] is loaded into the 4-bit pointer, the block ACKs (PTR_ACK), and the FSM moves to WDATA.
REQ-013 WDATA: each received byte is written to reg[ptr], the block ACKs (WDATA_ACK), and ptr increments mod 16 (15 wraps to 0).
REQ-014 The write-event flag SHALL be set when a WDATA byte completes.
REQ-015 RDATA byte load and drive:
- reg[ptr] is loaded into the TX shift register on the SCL falling edge that ends the preceding ACK phase.
- The block drives SDA low for each 0 bit and releases it for each 1 bit.
- ptr increments mod 16 after the byte is loaded.
REQ-016 RACK: the block releases SDA and samples the master's ACK.
- ACK (0): the FSM returns to RDATA.
- NACK (1): the FSM goes to IDLE with SDA released.
REQ-017 STOP SHALL send the FSM to IDLE and release SDA.
REQ-018 If the write-event flag was set during the transaction, STOP SHALL set intr=1 and clear the flag.
REQ-019 Wishbone accesses:
- wb_ack_o is asserted for exactly one cycle, the cycle after wb_stb_i&wb_cyc_i is first seen high.
- wb_ack_o is deasserted for at least one cycle before the next ack.
REQ-020 Wishbone decode, adr[6:2]:
- 0-15 select reg[n], with the data in wb_dat_o[7:0].
- 16 selects status, read as {30'b0, busy, intr}; busy is high whenever the FSM is not IDLE.
- Any other decode reads 0, and writes to it are ignored.
REQ-021 A Wishbone write to status with dat[0]=1 SHALL clear intr.
REQ-022 A Wishbone write to reg[n] SHALL take effect only if wb_sel_i[0]=1.
REQ-023 If a Wishbone write and an I2C write target the same register in the same cycle, the I2C write SHALL win.
REQ-024 If intr clear and intr set occur in the same cycle, set SHALL win.
REQ-025 wb_dat_o[31:8] SHALL always be 0.

Reset
REQ-026 On reset the FSM SHALL be IDLE with SDA released (high-Z).
REQ-027 On reset ptr, the bit counter, the write-event flag, intr, wb_ack_o and wb_dat_o SHALL be 0, and all 16 registers SHALL be 8'h00.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer immediately: SDA is released and the block responds only after the next START.

Verification
REQ-029 I2C write: START, 0x84 (0x42+W), 0x03, 0xA5, 0x5A, STOP -> all three bytes ACKed; reg3=0xA5, reg4=0x5A; intr=1; a WB read of adr 0x40 returns 0x1.
REQ-030 Read with wrap: WB writes reg15=0x11 and reg0=0x22; I2C sends 0x84, 0x0F, repeated START, 0x85, then reads two bytes with ACK then NACK -> data 0x11, 0x22; SDA released after the NACK; intr stays 0.
REQ-031 Address mismatch: START, 0x90 -> SDA never driven; no register changes; busy=0 after the 9th SCL.
REQ-032 Collision: an I2C write to reg5 and a WB write of 0x33 to adr 0x14 land in the same cycle -> reg5 holds the I2C byte.
REQ-033 Reset mid-read: reset pulsed during bit 4 of RDATA -> SDA goes high-Z the next cycle; all registers read 0; the next valid transaction completes normally.
REQ-034 intr clear: with intr=1, a WB write of 0x1 to adr 0x40 -> intr=0, and wb_ack_o is high for exactly 1 cycle.

Source files
------------

// File: rtl/i2c_target_wb.sv
// I2C target with a 16-byte register file and a Wishbone port.
// Wishbone acks the cycle after strobe; I2C events lag the bus by a 3-flop pipeline.
module i2c_target_wb #(
    parameter logic [6:0] I2C_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    input  logic        i2c_scl,
    inout  wire         i2c_sda,
    output logic        intr
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
    } state_t;

    state_t      state;
    logic [1:0]  scl_sync, sda_sync;
    logic        scl_d, sda_d;
    logic        sda_oe;
    logic [3:0]  bit_cnt;
    logic [6:0]  shift;
    logic [7:0]  tx;
    logic        rw;
    logic [3:0]  ptr;
    logic        wr_evt;
    logic [7:0]  regs [16];

    logic        scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    logic [4:0]  wb_idx;
    logic        wb_go;
    logic        unused_ok;

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign wb_idx    = wb_adr_i[6:2];
    assign wb_go     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
    assign unused_ok = ^{wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            // Synchronizers reset to the idle-bus level so no false edge follows reset.
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            sda_oe   <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= '0;
            rw       <= 1'b0;
            ptr      <= '0;
            wr_evt   <= 1'b0;
            intr     <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            scl_sync <= {scl_sync[0], i2c_scl};
            sda_sync <= {sda_sync[0], i2c_sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;

            // Wishbone writes come first so same-cycle I2C writes and intr sets override them.
            if (wb_go && wb_we_i) begin
                if (!wb_idx[4] && wb_sel_i[0]) regs[wb_idx[3:0]] <= wb_dat_i[7:0];
                else if (wb_idx == 5'd16 && wb_dat_i[0]) intr <= 1'b0;
            end

            if (scl_rise) shift <= {shift[5:0], sda_s};

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                if (wr_evt) begin
                    intr   <= 1'b1;
                    wr_evt <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: ;
                    ADDR, PTR, WDATA: if (scl_rise) begin
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            if (state == ADDR) begin
                                if (shift == I2C_ADDR) begin
                                    rw    <= sda_s;
                                    state <= ADDR_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == PTR) begin
                                ptr   <= {shift[2:0], sda_s};
                                state <= PTR_ACK;
                            end else begin
                                regs[ptr] <= {shift, sda_s};
                                ptr       <= ptr + 1'b1;
                                wr_evt    <= 1'b1;
                                state     <= WDATA_ACK;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    // bit_cnt 0: fall that opens the ACK slot; 1: fall that closes it.
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (bit_cnt == 4'd0) begin
                            sda_oe  <= 1'b1;
                            bit_cnt <= 4'd1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            if (state == ADDR_ACK && rw) begin
                                tx     <= regs[ptr];
                                sda_oe <= ~regs[ptr][7];
                                ptr    <= ptr + 1'b1;
                                state  <= RDATA;
                            end else if (state == ADDR_ACK) begin
                                state <= PTR;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 1'b1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= '0;
                                state   <= RACK;
                            end else begin
                                sda_oe <= ~tx[6];
                                tx     <= {tx[6:0], 1'b0};
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_s) state <= IDLE;
                            else bit_cnt <= 4'd1;
                        end
                        if (scl_fall && bit_cnt == 4'd1) begin
                            tx      <= regs[ptr];
                            sda_oe  <= ~regs[ptr][7];
                            ptr     <= ptr + 1'b1;
                            bit_cnt <= '0;
                            state   <= RDATA;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_go;
            if (wb_go) begin
                if (!wb_idx[4]) wb_dat_o <= {24'b0, regs[wb_idx[3:0]]};
                else if (wb_idx == 5'd16) wb_dat_o <= {30'b0, state != IDLE, intr};
                else wb_dat_o <= '0;
            end
        end
    end
endmodule
